branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters, placed alongside the IF stage of the pipelined MIPS core.
- Gives IF a same-cycle predicted next PC. ID trains the table with resolved branch outcomes.
- Keeps saturating branch and mispredict statistics for performance bring-up.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- CNT_W, 2, direction counter width in bits; legal values 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  PC currently fetched by IF.
- pred_hit  out  1  valid entry with matching tag found for if_pc.
- pred_taken  out  1  predicted taken.
- pred_npc  out  XLEN  predicted next PC.
- upd_valid  in  1  ID resolved a branch/jump this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual target; meaningful when upd_taken=1.
- upd_pred_taken  in  1  prediction that was made for this instruction (pipelined from IF).
- upd_pred_npc  in  XLEN  predicted next PC that was made for this instruction.
- mispredict  out  1  registered pulse, one cycle after a mispredicted update.
- inv_all  in  1  synchronous invalidate of every entry.
- clr_stats  in  1  synchronous clear of both statistics counters.
- br_cnt  out  XLEN  count of resolved branches, saturating.
- mp_cnt  out  XLEN  count of mispredicts, saturating.

Behaviour:
- IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target[XLEN], cnt[CNT_W].
- Reset, asynchronous:
  - All valid bits=0; all cnt = weakly-not-taken (MSB 0, other bits 1; e.g. 01 for CNT_W=2).
  - Targets and tags are don't-care.
  - mispredict=0, br_cnt=0, mp_cnt=0.
- Lookup is combinational from registered state:
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && cnt[MSB].
  - pred_npc = pred_taken ? target : if_pc+4, with wrap-around modulo 2^XLEN.
- Update, on the clock edge when upd_valid=1:
  - Hit, taken: cnt increments, saturating at all-ones; target <= upd_target.
  - Hit, not taken: cnt decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate into the indexed slot, overwriting any existing entry: valid=1, tag, target=upd_target, cnt = weakly-taken (MSB 1, rest 0).
  - Miss, not taken: no change.
- Mispredict condition: upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_npc != upd_target)).
  - The mispredict output is registered: high exactly the cycle after that condition holds, otherwise 0.
- Statistics:
  - br_cnt += 1 on every upd_valid.
  - mp_cnt += 1 on every mispredict condition.
  - Both saturate at all-ones and never wrap.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents. The update is visible from the next cycle, so no bypass.
- inv_all:
  - Clears every valid bit and resets every cnt to weakly-not-taken.
  - Has priority over an update in the same cycle; that update is dropped from the table but still counted in the statistics.
- clr_stats: zeroes both counters. It has priority over increments in the same cycle.
- Reset asserted mid-operation returns all state to reset values immediately. No partial update is retained.
- No stall input: IF holds if_pc during stalls. ID must present upd_valid once per resolved instruction; duplicate updates are trained twice.

Decomposition:
- Shared package bp_pkg:
  - Counter-encoding helper functions: weak_nt(CNT_W), weak_t(CNT_W).
  - Index/tag width function clog2.
  - Localparam computation of IDX_W and TAG_W.
- One sub-module, sat_cnt:
  - CNT_W-bit saturating up/down counter with inc, dec, load and load value.
  - Instanced per entry.
- The statistics counters reuse a generic sat_inc function from bp_pkg.

Test Plan:
- Reset, then if_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_npc=0x00000044; br_cnt=mp_cnt=0.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> next cycle mispredict=1 and lookup 0x40 gives hit=1, taken=1, npc=0x100; br_cnt=1, mp_cnt=1.
- Four not-taken updates at 0x40 (ENTRIES=16) -> cnt walks 10->01->00->00; lookup returns hit=1, taken=0, npc=0x44; fifth taken update gives cnt=01, still not taken.
- Aliasing: entry at 0x40, then taken update pc=0x80 (same index 0, different tag) -> lookup 0x40 misses and 0x80 hits with the new target.
- Same-cycle lookup/update on 0x40 -> lookup shows old state that cycle and new state the next; inv_all with simultaneous update -> all lookups miss, br_cnt still increments.
- Force br_cnt to 0xFFFFFFFE via repeated updates (or a small XLEN=8 build: 254 updates) -> two more updates leave it at all-ones; clr_stats then reads 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: geometry helpers, direction
// counter encodings, the saturating statistics increment and the per-cycle
// table action type.
package bp_pkg;

  // Widest direction counter the encoding helpers support.
  localparam int MAX_CNT_W = 4;

  // Ceiling log2, used to size the index field from the entry count.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Default geometry of the core's predictor instance.
  localparam int DEF_XLEN    = 32;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_CNT_W   = 2;
  localparam int DEF_IDX_W   = clog2(DEF_ENTRIES);
  localparam int DEF_TAG_W   = DEF_XLEN - DEF_IDX_W - 2;

  // Weakly-not-taken: MSB clear, every lower bit set (01 for a 2-bit counter).
  function automatic logic [MAX_CNT_W-1:0] weak_nt(input int w);
    return MAX_CNT_W'((1 << (w - 1)) - 1);
  endfunction

  // Weakly-taken: MSB set, every lower bit clear (10 for a 2-bit counter).
  function automatic logic [MAX_CNT_W-1:0] weak_t(input int w);
    return MAX_CNT_W'(1 << (w - 1));
  endfunction

  // Increment a w-bit value held in the low bits of v, sticking at all-ones.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v == max_v) ? v : v + 64'd1;
  endfunction

  // What a resolved branch does to its indexed table slot this cycle.
  typedef enum logic [1:0] {
    UPD_NONE,   // no table change
    UPD_INC,    // hit, taken: strengthen towards taken, refresh target
    UPD_DEC,    // hit, not taken: weaken towards not taken
    UPD_ALLOC   // miss, taken: (re)allocate the slot
  } upd_act_e;

endpackage

// File: rtl/branch_predictor_sat_cnt.sv
// Small saturating up/down counter holding one BTB entry's direction state.
// Load wins over count; counting sticks at all-ones and at zero.
module sat_cnt #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Counter register: load, else saturating increment or decrement.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      if (r_cnt != '1) r_cnt <= r_cnt + W'(1);
    end else if (i_dec) begin
      if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// IF gets a same-cycle predicted next PC from registered state; ID trains the
// table with resolved outcomes, visible from the following cycle (no bypass).
// Resolved-branch and mispredict counts saturate for performance bring-up.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_npc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_npc,
  output logic            mispredict,
  input  logic            inv_all,
  input  logic            clr_stats,
  output logic [XLEN-1:0] br_cnt,
  output logic [XLEN-1:0] mp_cnt
);

  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(weak_nt(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(weak_t(CNT_W));

  // Table state.
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [CNT_W-1:0]   w_cnt    [ENTRIES];

  // Statistics and mispredict pulse.
  logic            r_mispredict;
  logic [XLEN-1:0] r_br_cnt;
  logic [XLEN-1:0] r_mp_cnt;

  // Address fields; the byte offset pc[1:0] plays no part.
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_unused;

  assign w_if_idx  = if_pc[IDX_W+1:2];
  assign w_if_tag  = if_pc[XLEN-1:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign w_unused  = ^{if_pc[1:0], upd_pc[1:0]};

  logic            w_upd_hit;
  upd_act_e        w_act;
  logic            w_mp_cond;
  logic [XLEN-1:0] w_br_next;
  logic [XLEN-1:0] w_mp_next;

  // IF lookup, purely from registered table contents.
  always_comb begin
    pred_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    pred_taken = pred_hit && w_cnt[w_if_idx][CNT_W-1];
    pred_npc   = pred_taken ? r_target[w_if_idx] : (if_pc + XLEN'(4));
  end

  // Decide what the resolved branch does to its slot; inv_all drops it.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_act     = UPD_NONE;
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    if (upd_valid && !inv_all) begin
      if (w_upd_hit)      w_act = upd_taken ? UPD_INC : UPD_DEC;
      else if (upd_taken) w_act = UPD_ALLOC;
    end
  end

  // Mispredict: wrong direction, or right "taken" to the wrong place.
  assign w_mp_cond = upd_valid &&
                     ((upd_pred_taken != upd_taken) ||
                      (upd_taken && (upd_pred_npc != upd_target)));

  assign w_br_next = XLEN'(sat_inc(64'(r_br_cnt), XLEN));
  assign w_mp_next = XLEN'(sat_inc(64'(r_mp_cnt), XLEN));

  // One direction counter per entry; inv_all reloads them all to weak-NT.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic w_sel;
    assign w_sel = (w_upd_idx == IDX_W'(g));

    sat_cnt #(
      .W       (CNT_W),
      .RST_VAL (CNT_WNT)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_inc      (w_sel && (w_act == UPD_INC)),
      .i_dec      (w_sel && (w_act == UPD_DEC)),
      .i_load     (inv_all || (w_sel && (w_act == UPD_ALLOC))),
      .i_load_val (inv_all ? CNT_WNT : CNT_WT),
      .o_cnt      (w_cnt[g])
    );
  end

  // Valid bits: cleared by reset and inv_all, set on allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (inv_all) begin
      r_valid <= '0;
    end else if (w_act == UPD_ALLOC) begin
      r_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Tag and target storage, written on allocation; target refreshed on taken hits.
  // NOTE: tags and targets are array storage with no reset; they are only
  // observed behind a valid bit, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (w_act == UPD_ALLOC) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= upd_target;
    end else if (w_act == UPD_INC) begin
      r_target[w_upd_idx] <= upd_target;
    end
  end

  // Registered mispredict pulse and saturating statistics; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict <= 1'b0;
      r_br_cnt     <= '0;
      r_mp_cnt     <= '0;
    end else begin
      r_mispredict <= w_mp_cond;
      if (clr_stats) begin
        r_br_cnt <= '0;
        r_mp_cnt <= '0;
      end else begin
        if (upd_valid) r_br_cnt <= w_br_next;
        if (w_mp_cond) r_mp_cnt <= w_mp_next;
      end
    end
  end

  assign mispredict = r_mispredict;
  assign br_cnt     = r_br_cnt;
  assign mp_cnt     = r_mp_cnt;

endmodule
